// File: rtl/dc_seq.sv
// ============================================================================
// Module   : dc_seq
// Brief    : DC303 microsequencer: micro-PC, microinstruction register,
//            return stack and trap vectoring for the microcode ROM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dc_seq #(
    parameter logic [8:0] RST_ADDR  = 9'h001,
    parameter int         STK_DEPTH = 4
) (
    input  logic        pin_clk,
    input  logic        pin_rst_n,
    output logic [9:0]  rom_a,
    input  logic [8:0]  rom_ma,
    input  logic [15:0] rom_mc,
    input  logic [2:0]  seq_op,
    input  logic [3:0]  cond,
    input  logic [8:0]  pla_addr,
    input  logic        pla_ax,
    input  logic [8:0]  target,
    input  logic        stall,
    input  logic        trap_req,
    input  logic [8:0]  trap_vec,
    output logic        trap_ack,
    output logic [15:0] mir,
    output logic        mir_valid,
    output logic [8:0]  upc,
    output logic        stk_err
);

    localparam int PW = $clog2(STK_DEPTH + 1);
    localparam int IW = $clog2(STK_DEPTH);

    localparam logic [2:0]    OP_BRANCH   = 3'd1;
    localparam logic [2:0]    OP_DISPATCH = 3'd2;
    localparam logic [2:0]    OP_CALL     = 3'd3;
    localparam logic [2:0]    OP_RETURN   = 3'd4;
    localparam logic [PW-1:0] SP_FULL     = PW'(STK_DEPTH);

    logic [8:0]    upc_q, upc_d;
    logic          ax_q, ax_d;
    logic [15:0]   mir_q;
    logic          mir_valid_q;
    logic          trap_ack_q, trap_ack_d;
    logic          stk_err_q, stk_err_d;
    logic [PW-1:0] sp_q, sp_d;
    logic [8:0]    stk_q [STK_DEPTH];
    logic          push;
    logic [IW-1:0] push_idx;
    logic [IW-1:0] top_idx;

    assign push_idx = IW'(sp_q);
    assign top_idx  = IW'(sp_q - 1'b1);

    always_comb begin
        upc_d      = upc_q;
        ax_d       = ax_q;
        sp_d       = sp_q;
        stk_err_d  = stk_err_q;
        trap_ack_d = 1'b0;
        push       = 1'b0;
        if (!stall) begin
            if (trap_req) begin
                upc_d      = trap_vec;
                ax_d       = 1'b0;
                trap_ack_d = 1'b1;
            end else begin
                case (seq_op)
                    OP_BRANCH:   upc_d = {rom_ma[8:4], rom_ma[3:0] | cond};
                    OP_DISPATCH: begin
                        upc_d = pla_addr;
                        ax_d  = pla_ax;
                    end
                    OP_CALL: begin
                        upc_d = target;
                        // A full stack drops the return point but still jumps.
                        if (sp_q == SP_FULL) begin
                            stk_err_d = 1'b1;
                        end else begin
                            push = 1'b1;
                            sp_d = sp_q + 1'b1;
                        end
                    end
                    OP_RETURN: begin
                        if (sp_q == '0) begin
                            upc_d     = rom_ma;
                            stk_err_d = 1'b1;
                        end else begin
                            upc_d = stk_q[top_idx];
                            sp_d  = sp_q - 1'b1;
                        end
                    end
                    default:     upc_d = rom_ma;
                endcase
            end
        end
    end

    always_ff @(posedge pin_clk or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            upc_q       <= RST_ADDR;
            ax_q        <= 1'b0;
            mir_q       <= '0;
            mir_valid_q <= 1'b0;
            trap_ack_q  <= 1'b0;
            stk_err_q   <= 1'b0;
            sp_q        <= '0;
            for (int i = 0; i < STK_DEPTH; i++) begin
                stk_q[i] <= '0;
            end
        end else begin
            upc_q      <= upc_d;
            ax_q       <= ax_d;
            trap_ack_q <= trap_ack_d;
            stk_err_q  <= stk_err_d;
            sp_q       <= sp_d;
            if (!stall) begin
                mir_q       <= rom_mc;
                mir_valid_q <= 1'b1;
            end
            if (push) begin
                stk_q[push_idx] <= rom_ma;
            end
        end
    end

    assign rom_a     = {ax_q, upc_q};
    assign upc       = upc_q;
    assign mir       = mir_q;
    assign mir_valid = mir_valid_q;
    assign trap_ack  = trap_ack_q;
    assign stk_err   = stk_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dc_seq.sv
// ============================================================================
// Module   : tb_dc_seq
// Brief    : Vector-table bench for dc_seq with an expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dc_seq;

    logic        pin_clk;
    logic        pin_rst_n;
    logic [9:0]  rom_a;
    logic [8:0]  rom_ma;
    logic [15:0] rom_mc;
    logic [2:0]  seq_op;
    logic [3:0]  cond;
    logic [8:0]  pla_addr;
    logic        pla_ax;
    logic [8:0]  target;
    logic        stall;
    logic        trap_req;
    logic [8:0]  trap_vec;
    logic        trap_ack;
    logic [15:0] mir;
    logic        mir_valid;
    logic [8:0]  upc;
    logic        stk_err;

    int checks   = 0;
    int failures = 0;

    dc_seq #(.RST_ADDR(9'h001), .STK_DEPTH(4)) dut (
        .pin_clk   (pin_clk),
        .pin_rst_n (pin_rst_n),
        .rom_a     (rom_a),
        .rom_ma    (rom_ma),
        .rom_mc    (rom_mc),
        .seq_op    (seq_op),
        .cond      (cond),
        .pla_addr  (pla_addr),
        .pla_ax    (pla_ax),
        .target    (target),
        .stall     (stall),
        .trap_req  (trap_req),
        .trap_vec  (trap_vec),
        .trap_ack  (trap_ack),
        .mir       (mir),
        .mir_valid (mir_valid),
        .upc       (upc),
        .stk_err   (stk_err)
    );

    initial pin_clk = 1'b0;
    always #5 pin_clk = ~pin_clk;

    typedef struct {
        logic [2:0]  op;
        logic [8:0]  ma;
        logic [15:0] mc;
        logic [3:0]  cnd;
        logic [8:0]  pla;
        logic        pax;
        logic [8:0]  tgt;
        logic        stl;
        logic        trq;
        logic [8:0]  tvec;
        logic [9:0]  e_a;
        logic [15:0] e_mir;
        logic        e_ack;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [9:0]  a;
        logic [15:0] m;
        logic        ack;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic [2:0] op, input logic [8:0] ma,
                                input logic [15:0] mc, input logic [3:0] cnd,
                                input logic [8:0] pla, input logic pax,
                                input logic [8:0] tgt, input logic stl,
                                input logic trq, input logic [8:0] tvec,
                                input logic [9:0] e_a, input logic [15:0] e_mir,
                                input logic e_ack, input logic e_err);
        vec_t v;
        v.op = op; v.ma = ma; v.mc = mc; v.cnd = cnd; v.pla = pla; v.pax = pax;
        v.tgt = tgt; v.stl = stl; v.trq = trq; v.tvec = tvec;
        v.e_a = e_a; v.e_mir = e_mir; v.e_ack = e_ack; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        seq_op = v.op; rom_ma = v.ma; rom_mc = v.mc; cond = v.cnd;
        pla_addr = v.pla; pla_ax = v.pax; target = v.tgt;
        stall = v.stl; trap_req = v.trq; trap_vec = v.tvec;
    endtask

    task automatic build_table();
        // op  ma      mc        cond  pla     pax  tgt    stl  trq  tvec   rom_a   mir      ack  err
        vecs.push_back(mk(3'd0, 9'h005, 16'hA001, 4'h0, 9'h000, 0, 9'h000, 0, 0, 9'h000, 10'h005, 16'hA001, 0, 0));
        vecs.push_back(mk(3'd0, 9'h00A, 16'hA005, 4'h0, 9'h000, 0, 9'h000, 0, 0, 9'h000, 10'h00A, 16'hA005, 0, 0));
        vecs.push_back(mk(3'd0, 9'h010, 16'hA00A, 4'h0, 9'h000, 0, 9'h000, 0, 0, 9'h000, 10'h010, 16'hA00A, 0, 0));
        vecs.push_back(mk(3'd1, 9'h120, 16'hB010, 4'h5, 9'h000, 0, 9'h000, 0, 0, 9'h000, 10'h125, 16'hB010, 0, 0));
        vecs.push_back(mk(3'd2, 9'h000, 16'hD125, 4'h0, 9'h0C3, 1, 9'h000, 0, 0, 9'h000, 10'h2C3, 16'hD125, 0, 0));
        vecs.push_back(mk(3'd0, 9'h044, 16'h1111, 4'h0, 9'h000, 0, 9'h000, 0, 0, 9'h000, 10'h244, 16'h1111, 0, 0));
        vecs.push_back(mk(3'd3, 9'h033, 16'hC044, 4'h0, 9'h000, 0, 9'h150, 0, 0, 9'h000, 10'h350, 16'hC044, 0, 0));
        vecs.push_back(mk(3'd4, 9'h077, 16'hC150, 4'h0, 9'h000, 0, 9'h000, 0, 0, 9'h000, 10'h233, 16'hC150, 0, 0));
        vecs.push_back(mk(3'd2, 9'h000, 16'hD033, 4'h0, 9'h040, 0, 9'h000, 0, 0, 9'h000, 10'h040, 16'hD033, 0, 0));
        // Five nested calls against a four-entry stack.
        vecs.push_back(mk(3'd3, 9'h101, 16'hE001, 4'h0, 9'h000, 0, 9'h060, 0, 0, 9'h000, 10'h060, 16'hE001, 0, 0));
        vecs.push_back(mk(3'd3, 9'h102, 16'hE002, 4'h0, 9'h000, 0, 9'h061, 0, 0, 9'h000, 10'h061, 16'hE002, 0, 0));
        vecs.push_back(mk(3'd3, 9'h103, 16'hE003, 4'h0, 9'h000, 0, 9'h062, 0, 0, 9'h000, 10'h062, 16'hE003, 0, 0));
        vecs.push_back(mk(3'd3, 9'h104, 16'hE004, 4'h0, 9'h000, 0, 9'h063, 0, 0, 9'h000, 10'h063, 16'hE004, 0, 0));
        vecs.push_back(mk(3'd3, 9'h105, 16'hE005, 4'h0, 9'h000, 0, 9'h064, 0, 0, 9'h000, 10'h064, 16'hE005, 0, 1));
        vecs.push_back(mk(3'd4, 9'h1FF, 16'hF001, 4'h0, 9'h000, 0, 9'h000, 0, 0, 9'h000, 10'h104, 16'hF001, 0, 1));
        vecs.push_back(mk(3'd4, 9'h1FF, 16'hF002, 4'h0, 9'h000, 0, 9'h000, 0, 0, 9'h000, 10'h103, 16'hF002, 0, 1));
        vecs.push_back(mk(3'd4, 9'h1FF, 16'hF003, 4'h0, 9'h000, 0, 9'h000, 0, 0, 9'h000, 10'h102, 16'hF003, 0, 1));
        vecs.push_back(mk(3'd4, 9'h1FF, 16'hF004, 4'h0, 9'h000, 0, 9'h000, 0, 0, 9'h000, 10'h101, 16'hF004, 0, 1));
        vecs.push_back(mk(3'd4, 9'h0AB, 16'hF005, 4'h0, 9'h000, 0, 9'h000, 0, 0, 9'h000, 10'h0AB, 16'hF005, 0, 1));
        // Trap coincident with a CALL: no push, ax cleared, one-cycle ack.
        vecs.push_back(mk(3'd3, 9'h0B0, 16'h7001, 4'h0, 9'h000, 0, 9'h0C0, 0, 0, 9'h000, 10'h0C0, 16'h7001, 0, 1));
        vecs.push_back(mk(3'd2, 9'h000, 16'h7002, 4'h0, 9'h0C1, 1, 9'h000, 0, 0, 9'h000, 10'h2C1, 16'h7002, 0, 1));
        vecs.push_back(mk(3'd3, 9'h0D0, 16'h7003, 4'h0, 9'h000, 0, 9'h0E0, 0, 1, 9'h1F0, 10'h1F0, 16'h7003, 1, 1));
        vecs.push_back(mk(3'd0, 9'h1F1, 16'h7004, 4'h0, 9'h000, 0, 9'h000, 0, 0, 9'h000, 10'h1F1, 16'h7004, 0, 1));
        vecs.push_back(mk(3'd4, 9'h111, 16'h7005, 4'h0, 9'h000, 0, 9'h000, 0, 0, 9'h000, 10'h0B0, 16'h7005, 0, 1));
        vecs.push_back(mk(3'd4, 9'h123, 16'h7006, 4'h0, 9'h000, 0, 9'h000, 0, 0, 9'h000, 10'h123, 16'h7006, 0, 1));
        // Stall with a pending trap, then resume.
        vecs.push_back(mk(3'd0, 9'h050, 16'h5050, 4'h0, 9'h000, 0, 9'h000, 0, 0, 9'h000, 10'h050, 16'h5050, 0, 1));
        vecs.push_back(mk(3'd3, 9'h077, 16'hDEAD, 4'h0, 9'h000, 0, 9'h0AA, 1, 1, 9'h1F0, 10'h050, 16'h5050, 0, 1));
        vecs.push_back(mk(3'd3, 9'h077, 16'hDEAD, 4'h0, 9'h000, 0, 9'h0AA, 1, 1, 9'h1F0, 10'h050, 16'h5050, 0, 1));
        vecs.push_back(mk(3'd3, 9'h077, 16'hDEAD, 4'h0, 9'h000, 0, 9'h0AA, 1, 1, 9'h1F0, 10'h050, 16'h5050, 0, 1));
        vecs.push_back(mk(3'd0, 9'h051, 16'h6060, 4'h0, 9'h000, 0, 9'h000, 0, 0, 9'h000, 10'h051, 16'h6060, 0, 1));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".rom_a"},     16'(rom_a),     16'h0001);
        check({tag, ".upc"},       16'(upc),       16'h0001);
        check({tag, ".mir"},       mir,            16'h0000);
        check({tag, ".mir_valid"}, 16'(mir_valid), 16'h0000);
        check({tag, ".trap_ack"},  16'(trap_ack),  16'h0000);
        check({tag, ".stk_err"},   16'(stk_err),   16'h0000);
    endtask

    initial begin
        exp_t e;
        pin_rst_n = 1'b0;
        drive(mk(3'd0, 9'h0, 16'h0, 4'h0, 9'h0, 0, 9'h0, 0, 0, 9'h0, 10'h0, 16'h0, 0, 0));
        build_table();
        repeat (2) @(posedge pin_clk);
        #1;
        check_reset_state("reset");
        @(negedge pin_clk);
        pin_rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            e.a = vecs[i].e_a; e.m = vecs[i].e_mir; e.ack = vecs[i].e_ack; e.err = vecs[i].e_err;
            sb.push_back(e);
            @(posedge pin_clk);
            #1;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard: queue empty at vector %0d", i);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d.rom_a", i),     16'(rom_a),     16'(e.a));
                check($sformatf("v%0d.upc", i),       16'(upc),       16'(e.a[8:0]));
                check($sformatf("v%0d.mir", i),       mir,            e.m);
                check($sformatf("v%0d.mir_valid", i), 16'(mir_valid), 16'h0001);
                check($sformatf("v%0d.trap_ack", i),  16'(trap_ack),  16'(e.ack));
                check($sformatf("v%0d.stk_err", i),   16'(stk_err),   16'(e.err));
            end
        end

        // Asynchronous reset taken in the middle of a stall with a trap pending.
        stall = 1'b1; trap_req = 1'b1; trap_vec = 9'h1F0;
        @(posedge pin_clk);
        #1;
        check("midstall.rom_a_frozen", 16'(rom_a), 16'h0051);
        @(negedge pin_clk);
        #2;
        pin_rst_n = 1'b0;
        #1;
        check_reset_state("midstall_rst");
        @(negedge pin_clk);
        stall = 1'b0; trap_req = 1'b0; seq_op = 3'd0; rom_ma = 9'h002;
        pin_rst_n = 1'b1;
        @(posedge pin_clk);
        #1;
        check("post_rst.rom_a", 16'(rom_a), 16'h0002);
        check("post_rst.trap_ack", 16'(trap_ack), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
